// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: widths, flag bit indices,
// FSM states and the opcode map.
package alu_seq_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int IR_W_DEF   = 8;

   // Flag register layout {C,Z,S,V,P}
   localparam int FLAG_C = 4;
   localparam int FLAG_Z = 3;
   localparam int FLAG_S = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_P = 0;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   typedef logic [7:0] opcode_t;

   // Arithmetic / logic
   localparam opcode_t OP_ADD  = 8'h00;
   localparam opcode_t OP_ADC  = 8'h01;
   localparam opcode_t OP_SUB  = 8'h02;
   localparam opcode_t OP_CMP  = 8'h03;
   localparam opcode_t OP_INC  = 8'h04;
   localparam opcode_t OP_DEC  = 8'h05;
   localparam opcode_t OP_NEG  = 8'h06;
   localparam opcode_t OP_AND  = 8'h07;
   localparam opcode_t OP_OR   = 8'h08;
   localparam opcode_t OP_XOR  = 8'h09;
   localparam opcode_t OP_TEST = 8'h0A;
   localparam opcode_t OP_NOT  = 8'h0B;
   localparam opcode_t OP_SETC = 8'h0C;
   localparam opcode_t OP_CLC  = 8'h0D;
   // Shifts / rotates (contiguous range)
   localparam opcode_t OP_SHRS = 8'h10;
   localparam opcode_t OP_SHRA = 8'h11;
   localparam opcode_t OP_SHLS = 8'h12;
   localparam opcode_t OP_SHLA = 8'h13;
   localparam opcode_t OP_ROL  = 8'h14;
   localparam opcode_t OP_ROR  = 8'h15;
   localparam opcode_t OP_RCL  = 8'h16;
   localparam opcode_t OP_RCR  = 8'h17;
   // Jumps (contiguous range)
   localparam opcode_t OP_JMP  = 8'h20;
   localparam opcode_t OP_JE   = 8'h21;
   localparam opcode_t OP_JNE  = 8'h22;
   localparam opcode_t OP_JB   = 8'h23;
   localparam opcode_t OP_JAE  = 8'h24;
   localparam opcode_t OP_JA   = 8'h25;
   localparam opcode_t OP_JBE  = 8'h26;
   localparam opcode_t OP_JL   = 8'h27;
   localparam opcode_t OP_JGE  = 8'h28;
   localparam opcode_t OP_JG   = 8'h29;
   localparam opcode_t OP_JLE  = 8'h2A;
   localparam opcode_t OP_JS   = 8'h2B;
   localparam opcode_t OP_JNS  = 8'h2C;
   localparam opcode_t OP_JO   = 8'h2D;
   localparam opcode_t OP_JNO  = 8'h2E;
   localparam opcode_t OP_JP   = 8'h2F;
   localparam opcode_t OP_JNP  = 8'h30;

   function automatic logic is_shift(input opcode_t op);
      return (op >= OP_SHRS) && (op <= OP_RCR);
   endfunction

   function automatic logic is_jump(input opcode_t op);
      return (op >= OP_JMP) && (op <= OP_JNP);
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control FSM (master) and the ALU (slave).
interface alu_seq_if #(
   parameter int DATA_W  = 16,
   parameter int IR_W    = 8,
   parameter int SHAMT_W = $clog2(DATA_W)
);
   logic               start;
   logic [IR_W-1:0]    IR;
   logic [DATA_W-1:0]  in1;
   logic [DATA_W-1:0]  in2;
   logic [SHAMT_W-1:0] shift_amt;
   logic               busy;
   logic [DATA_W-1:0]  out;
   logic               out_valid;
   logic               wb_en;
   logic               cond_true;
   logic [4:0]         flags;

   modport master (
      output start, IR, in1, in2, shift_amt,
      input  busy, out, out_valid, wb_en, cond_true, flags
   );

   modport slave (
      input  start, IR, in1, in2, shift_amt,
      output busy, out, out_valid, wb_en, cond_true, flags
   );
endinterface

// File: rtl/alu_seq_cond_eval.sv
// Jump condition evaluator: (opcode, flags) -> verdict, x86 semantics.
// Purely combinational so the branch unit can share it.
module alu_seq_cond_eval
   import alu_seq_pkg::*;
(
   input  opcode_t    op,
   input  logic [4:0] flags,
   output logic       cond,
   output logic       is_jcc
);
   logic c_f, z_f, s_f, v_f, p_f;

   assign c_f    = flags[FLAG_C];
   assign z_f    = flags[FLAG_Z];
   assign s_f    = flags[FLAG_S];
   assign v_f    = flags[FLAG_V];
   assign p_f    = flags[FLAG_P];
   assign is_jcc = is_jump(op);

   // Condition decode; non-jump opcodes give 0
   always_comb begin
      cond = 1'b0;
      case (op)
         OP_JMP: cond = 1'b1;
         OP_JE:  cond = z_f;
         OP_JNE: cond = ~z_f;
         OP_JB:  cond = c_f;
         OP_JAE: cond = ~c_f;
         OP_JA:  cond = ~c_f & ~z_f;
         OP_JBE: cond = c_f | z_f;
         OP_JL:  cond = s_f ^ v_f;
         OP_JGE: cond = ~(s_f ^ v_f);
         OP_JG:  cond = ~z_f & ~(s_f ^ v_f);
         OP_JLE: cond = z_f | (s_f ^ v_f);
         OP_JS:  cond = s_f;
         OP_JNS: cond = ~s_f;
         OP_JO:  cond = v_f;
         OP_JNO: cond = ~v_f;
         OP_JP:  cond = p_f;
         OP_JNP: cond = ~p_f;
         default: cond = 1'b0;
      endcase
   end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with a persistent flag register. Single-cycle ops complete
// at the edge that samples start; shifts/rotates step one bit per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | accepts start; single-cycle ops and zero-count shifts finish
//   ST_SHIFT | one shift step per cycle, cnt_q counts down to the final step
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IR_W    = IR_W_DEF,
   parameter int SHAMT_W = $clog2(DATA_W)
) (
   input  logic    clk,
   input  logic    rst_n,
   alu_seq_if.slave bus
);
   localparam int                 MSB    = DATA_W - 1;
   localparam logic [DATA_W:0]    ONE_X  = {{DATA_W{1'b0}}, 1'b1};
   localparam logic [DATA_W:0]    ZERO_X = '0;
   localparam logic [DATA_W-1:0]  MIN_V  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [SHAMT_W-1:0] CNT_1  = {{(SHAMT_W-1){1'b0}}, 1'b1};

   state_t             state_q;
   logic [DATA_W-1:0]  out_q;
   logic [4:0]         flags_q;
   logic               out_valid_q, wb_en_q, cond_q;
   logic [DATA_W-1:0]  sh_q;
   logic               sc_q;
   opcode_t            sop_q;
   logic [SHAMT_W-1:0] cnt_q;

   logic [IR_W-1:0]    ir;
   opcode_t            op;
   logic [DATA_W-1:0]  a, b;
   logic [DATA_W:0]    ax, bx, cx, ext;
   logic               cond, is_jcc, upd_zsp;
   logic [DATA_W-1:0]  res_d;
   logic [4:0]         flg_d;
   logic               wb_d, cond_d;
   logic [DATA_W-1:0]  step_v;
   logic               step_c;

   assign ir = bus.IR;
   assign op = opcode_t'(ir);
   assign a  = bus.in1;
   assign b  = bus.in2;
   assign ax = {1'b0, a};
   assign bx = {1'b0, b};
   assign cx = {{DATA_W{1'b0}}, flags_q[FLAG_C]};

   alu_seq_cond_eval u_cond (
      .op     (op),
      .flags  (flags_q),
      .cond   (cond),
      .is_jcc (is_jcc)
   );

   // Single-cycle result and flag update for the op presented with start
   always_comb begin
      res_d   = out_q;
      flg_d   = flags_q;
      wb_d    = 1'b0;
      cond_d  = 1'b0;
      ext     = '0;
      upd_zsp = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            ext = (op == OP_ADC) ? (ax + bx + cx) : (ax + bx);
            flg_d[FLAG_C] = ext[DATA_W];
            flg_d[FLAG_V] = (a[MSB] == b[MSB]) && (ext[MSB] != a[MSB]);
            res_d   = ext[DATA_W-1:0];
            wb_d    = 1'b1;
            upd_zsp = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            ext = ax - bx;
            flg_d[FLAG_C] = ext[DATA_W];
            flg_d[FLAG_V] = (a[MSB] != b[MSB]) && (ext[MSB] != a[MSB]);
            upd_zsp = 1'b1;
            if (op == OP_SUB) begin
               res_d = ext[DATA_W-1:0];
               wb_d  = 1'b1;
            end
         end
         OP_INC: begin
            ext = ax + ONE_X;
            flg_d[FLAG_V] = ~a[MSB] & ext[MSB];
            res_d   = ext[DATA_W-1:0];
            wb_d    = 1'b1;
            upd_zsp = 1'b1;
         end
         OP_DEC: begin
            ext = ax - ONE_X;
            flg_d[FLAG_V] = a[MSB] & ~ext[MSB];
            res_d   = ext[DATA_W-1:0];
            wb_d    = 1'b1;
            upd_zsp = 1'b1;
         end
         OP_NEG: begin
            ext = ZERO_X - ax;
            flg_d[FLAG_C] = (a != '0);
            flg_d[FLAG_V] = (a == MIN_V);
            res_d   = ext[DATA_W-1:0];
            wb_d    = 1'b1;
            upd_zsp = 1'b1;
         end
         OP_AND, OP_TEST, OP_OR, OP_XOR: begin
            if (op == OP_OR)       ext = {1'b0, a | b};
            else if (op == OP_XOR) ext = {1'b0, a ^ b};
            else                   ext = {1'b0, a & b};
            flg_d[FLAG_C] = 1'b0;
            flg_d[FLAG_V] = 1'b0;
            upd_zsp = 1'b1;
            if (op != OP_TEST) begin
               res_d = ext[DATA_W-1:0];
               wb_d  = 1'b1;
            end
         end
         OP_NOT: begin
            res_d = ~a;
            wb_d  = 1'b1;
         end
         OP_SETC: flg_d[FLAG_C] = 1'b1;
         OP_CLC:  flg_d[FLAG_C] = 1'b0;
         // Zero-count shift: pass operand through, flags untouched
         OP_SHRS, OP_SHRA, OP_SHLS, OP_SHLA,
         OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
            res_d = a;
            wb_d  = 1'b1;
         end
         default: begin
            if (is_jcc) begin
               res_d  = {DATA_W{cond}};
               cond_d = cond;
            end
         end
      endcase
      if (upd_zsp) begin
         flg_d[FLAG_Z] = (ext[DATA_W-1:0] == '0);
         flg_d[FLAG_S] = ext[MSB];
         flg_d[FLAG_P] = ~^ext[DATA_W-1:0];
      end
   end

   // One-bit shift/rotate step applied to the working register each SHIFT cycle
   always_comb begin
      step_v = sh_q;
      step_c = sc_q;
      case (sop_q)
         OP_SHRS: begin step_v = {1'b0, sh_q[MSB:1]};       step_c = sh_q[0];   end
         OP_SHRA: begin step_v = {sh_q[MSB], sh_q[MSB:1]};  step_c = sh_q[0];   end
         OP_SHLS,
         OP_SHLA: begin step_v = {sh_q[MSB-1:0], 1'b0};     step_c = sh_q[MSB]; end
         OP_ROL:  begin step_v = {sh_q[MSB-1:0], sh_q[MSB]}; step_c = sh_q[MSB]; end
         OP_ROR:  begin step_v = {sh_q[0], sh_q[MSB:1]};    step_c = sh_q[0];   end
         OP_RCL:  begin step_v = {sh_q[MSB-1:0], sc_q};     step_c = sh_q[MSB]; end
         OP_RCR:  begin step_v = {sc_q, sh_q[MSB:1]};       step_c = sh_q[0];   end
         default: begin step_v = sh_q;                      step_c = sc_q;      end
      endcase
   end

   // Control FSM with registered outputs; completion strobes default low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         wb_en_q     <= 1'b0;
         cond_q      <= 1'b0;
         sh_q        <= '0;
         sc_q        <= 1'b0;
         sop_q       <= OP_ADD;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= 1'b0;
         wb_en_q     <= 1'b0;
         cond_q      <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  if (is_shift(op) && (bus.shift_amt != '0)) begin
                     sh_q    <= a;
                     sc_q    <= flags_q[FLAG_C];
                     sop_q   <= op;
                     cnt_q   <= bus.shift_amt;
                     state_q <= ST_SHIFT;
                  end else begin
                     out_q       <= res_d;
                     flags_q     <= flg_d;
                     out_valid_q <= 1'b1;
                     wb_en_q     <= wb_d;
                     cond_q      <= cond_d;
                  end
               end
            end
            ST_SHIFT: begin
               sh_q  <= step_v;
               sc_q  <= step_c;
               cnt_q <= cnt_q - CNT_1;
               if (cnt_q == CNT_1) begin
                  out_q           <= step_v;
                  flags_q[FLAG_C] <= step_c;
                  flags_q[FLAG_V] <= step_v[MSB] ^ sh_q[MSB];
                  out_valid_q     <= 1'b1;
                  wb_en_q         <= 1'b1;
                  state_q         <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = (state_q == ST_SHIFT);
   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.wb_en     = wb_en_q;
   assign bus.cond_true = cond_q;
   assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
   import alu_seq_pkg::*;

   typedef struct {
      int          due;
      logic [15:0] out;
      logic [4:0]  flags;
      logic        wb;
      logic        cnd;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   bit   chk_en = 1'b0;

   exp_t        q[$];
   logic [15:0] m_out = '0;     // model state at issue time
   logic [4:0]  m_flags = '0;
   logic [15:0] held_out = '0;  // model view of the DUT registers
   logic [4:0]  held_flags = '0;
   int          sh_from = 0, sh_to = 0, rst_cyc = -1;

   alu_seq_if #(.DATA_W(16), .IR_W(8)) bus ();
   alu_seq #(.DATA_W(16), .IR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: timeout reached at cycle %0d, required completion", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h, required %h", nm, cyc, act, exp);
   endtask

   function automatic logic cond_of(input opcode_t op, input logic [4:0] f);
      logic c, z, s, v, p;
      {c, z, s, v, p} = f;
      case (op)
         OP_JMP: return 1'b1;
         OP_JE:  return z;
         OP_JNE: return !z;
         OP_JB:  return c;
         OP_JAE: return !c;
         OP_JA:  return !c && !z;
         OP_JBE: return c || z;
         OP_JL:  return s != v;
         OP_JGE: return s == v;
         OP_JG:  return !z && (s == v);
         OP_JLE: return z || (s != v);
         OP_JS:  return s;
         OP_JNS: return !s;
         OP_JO:  return v;
         OP_JNO: return !v;
         OP_JP:  return p;
         OP_JNP: return !p;
         default: return 1'b0;
      endcase
   endfunction

   // Whole-word result of shifting by k positions: {carry, value}
   function automatic logic [16:0] shiftk(input opcode_t op, input logic [15:0] a,
                                          input logic cin, input int k);
      int ai, sa, x, v, c;
      ai = int'(a);
      sa = int'($signed(a));
      x  = (int'(cin) << 16) | ai;
      v  = ai;
      c  = int'(cin);
      case (op)
         OP_ROL: begin v = ((ai << k) | (ai >> (16 - k))) & 'hFFFF; if (k > 0) c = v & 1; end
         OP_ROR: begin v = ((ai >> k) | (ai << (16 - k))) & 'hFFFF; if (k > 0) c = (v >> 15) & 1; end
         OP_RCL: begin
            x = ((x << k) | (x >> (17 - k))) & 'h1FFFF;
            c = x >> 16; v = x & 'hFFFF;
         end
         OP_RCR: begin
            x = ((x >> k) | (x << (17 - k))) & 'h1FFFF;
            c = x >> 16; v = x & 'hFFFF;
         end
         OP_SHRS: begin v = ai >> k; if (k > 0) c = (ai >> (k - 1)) & 1; end
         OP_SHRA: begin v = (sa >>> k) & 'hFFFF; if (k > 0) c = (ai >> (k - 1)) & 1; end
         default: begin v = (ai << k) & 'hFFFF; if (k > 0) c = (ai >> (16 - k)) & 1; end
      endcase
      return {c[0], v[15:0]};
   endfunction

   function automatic void model(input opcode_t op, input logic [15:0] a, input logic [15:0] b,
                                 input int n, input logic [4:0] fi, input logic [15:0] oi,
                                 output logic [15:0] o, output logic [4:0] fo,
                                 output logic wb, output logic cnd);
      int ai, bi, sa, sb, r, sr, cin;
      logic [15:0] res;
      logic zsp;
      logic [16:0] s1, s0;
      ai = int'(a); bi = int'(b);
      sa = int'($signed(a)); sb = int'($signed(b));
      o = oi; fo = fi; wb = 1'b0; cnd = 1'b0; zsp = 1'b0; res = '0;
      case (op)
         OP_ADD, OP_ADC: begin
            cin = (op == OP_ADC) ? int'(fi[4]) : 0;
            r = ai + bi + cin; sr = sa + sb + cin;
            res = r[15:0]; fo[4] = (r > 65535); fo[1] = (sr > 32767) || (sr < -32768);
            o = res; wb = 1'b1; zsp = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            r = ai - bi; sr = sa - sb;
            res = r[15:0]; fo[4] = (ai < bi); fo[1] = (sr > 32767) || (sr < -32768);
            zsp = 1'b1;
            if (op == OP_SUB) begin o = res; wb = 1'b1; end
         end
         OP_INC: begin r = ai + 1; res = r[15:0]; fo[1] = (sa + 1 > 32767); o = res; wb = 1'b1; zsp = 1'b1; end
         OP_DEC: begin r = ai - 1; res = r[15:0]; fo[1] = (sa - 1 < -32768); o = res; wb = 1'b1; zsp = 1'b1; end
         OP_NEG: begin
            r = -ai; res = r[15:0]; fo[4] = (ai != 0); fo[1] = (sa == -32768);
            o = res; wb = 1'b1; zsp = 1'b1;
         end
         OP_AND, OP_TEST, OP_OR, OP_XOR: begin
            res = (op == OP_OR) ? (a | b) : (op == OP_XOR) ? (a ^ b) : (a & b);
            fo[4] = 1'b0; fo[1] = 1'b0; zsp = 1'b1;
            if (op != OP_TEST) begin o = res; wb = 1'b1; end
         end
         OP_NOT:  begin o = ~a; wb = 1'b1; end
         OP_SETC: fo[4] = 1'b1;
         OP_CLC:  fo[4] = 1'b0;
         OP_SHRS, OP_SHRA, OP_SHLS, OP_SHLA, OP_ROL, OP_ROR, OP_RCL, OP_RCR: begin
            wb = 1'b1;
            if (n == 0) o = a;
            else begin
               s1 = shiftk(op, a, fi[4], n);
               s0 = shiftk(op, a, fi[4], n - 1);
               o = s1[15:0]; fo[4] = s1[16]; fo[1] = s1[15] ^ s0[15];
            end
         end
         default: begin
            if (op >= OP_JMP && op <= OP_JNP) begin
               cnd = cond_of(op, fi);
               o = cnd ? 16'hFFFF : 16'h0000;
            end
         end
      endcase
      if (zsp) begin
         fo[3] = (res == 16'h0);
         fo[2] = res[15];
         fo[0] = ($countones(res) % 2) == 0;
      end
   endfunction

   // Issue one op; called #1 after a posedge with the DUT idle
   task automatic issue(input opcode_t op, input logic [15:0] a, input logic [15:0] b,
                        input int n, input bit wait_done, input bit poke);
      exp_t e;
      int ne;
      ne = (op >= OP_SHRS && op <= OP_RCR) ? n : 0;
      model(op, a, b, n, m_flags, m_out, e.out, e.flags, e.wb, e.cnd);
      e.due = cyc + 1 + ne;
      q.push_back(e);
      m_out = e.out; m_flags = e.flags;
      if (ne > 0) begin sh_from = cyc + 1; sh_to = e.due; end
      bus.start = 1'b1; bus.IR = op; bus.in1 = a; bus.in2 = b; bus.shift_amt = 4'(n);
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (wait_done) begin
         while (cyc < e.due) begin
            if (poke && $urandom_range(0, 2) == 0) begin
               bus.start = 1'b1; bus.IR = OP_NOT; bus.in1 = 16'(($urandom));
            end else bus.start = 1'b0;
            @(posedge clk); #1;
         end
         bus.start = 1'b0;
      end
   endtask

   function automatic logic [15:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 16'h0000;
         1: return 16'h7FFF;
         2: return 16'h8000;
         3: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Compare process: DUT registers against the model every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         if (cyc == rst_cyc) begin held_out = '0; held_flags = '0; end
         while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
         chk("busy", 32'(bus.busy), 32'(cyc >= sh_from && cyc < sh_to));
         if (q.size() > 0 && q[0].due == cyc) begin
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("wb_en", 32'(bus.wb_en), 32'(q[0].wb));
            chk("cond_true", 32'(bus.cond_true), 32'(q[0].cnd));
            held_out = q[0].out; held_flags = q[0].flags;
            void'(q.pop_front());
         end else begin
            chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
            chk("wb_en_idle", 32'(bus.wb_en), 32'd0);
            chk("cond_idle", 32'(bus.cond_true), 32'd0);
         end
         chk("out", 32'(bus.out), 32'(held_out));
         chk("flags", 32'(bus.flags), 32'(held_flags));
      end
   end

   opcode_t op_list[$] = '{OP_ADD, OP_ADC, OP_SUB, OP_CMP, OP_INC, OP_DEC, OP_NEG, OP_AND,
                           OP_OR, OP_XOR, OP_TEST, OP_NOT, OP_SETC, OP_CLC, OP_SHRS, OP_SHRA,
                           OP_SHLS, OP_SHLA, OP_ROL, OP_ROR, OP_RCL, OP_RCR, OP_JMP, OP_JE,
                           OP_JNE, OP_JB, OP_JAE, OP_JA, OP_JBE, OP_JL, OP_JGE, OP_JG, OP_JLE,
                           OP_JS, OP_JNS, OP_JO, OP_JNO, OP_JP, OP_JNP, 8'hF0};

   initial begin
      logic [15:0] o;
      logic [4:0]  f;
      logic        wb, cn;
      opcode_t     op;
      int          n;

      // Hand-computed pins on the model itself
      model(OP_ADD, 16'h7FFF, 16'h0001, 0, 5'b00000, 16'h0, o, f, wb, cn);
      chk("pin_add_out", 32'(o), 32'h8000);
      chk("pin_add_flags", 32'(f), 32'b00110);
      model(OP_SUB, 16'h0003, 16'h0005, 0, 5'b00000, 16'h0, o, f, wb, cn);
      chk("pin_sub_out", 32'(o), 32'hFFFE);
      chk("pin_sub_flags", 32'(f), 32'b10100);
      model(OP_ADC, 16'hFFFF, 16'h0000, 0, 5'b10000, 16'h0, o, f, wb, cn);
      chk("pin_adc_flags", 32'({o, f}), 32'({16'h0000, 5'b11001}));
      model(OP_ROL, 16'h8001, 16'h0000, 4, 5'b00000, 16'h0, o, f, wb, cn);
      chk("pin_rol_out", 32'({o, f}), 32'({16'h0018, 5'b00000}));
      model(OP_JNE, 16'h0, 16'h0, 0, 5'b01001, 16'h1234, o, f, wb, cn);
      chk("pin_jne", 32'({o, cn, wb}), 32'({16'h0000, 1'b0, 1'b0}));

      bus.start = 1'b0; bus.IR = '0; bus.in1 = '0; bus.in2 = '0; bus.shift_amt = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_out", 32'(bus.out), 32'h0);
      chk("rst_flags", 32'(bus.flags), 32'h0);
      chk("rst_busy", 32'({bus.busy, bus.out_valid, bus.wb_en, bus.cond_true}), 32'h0);
      chk_en = 1'b1;

      // Directed scenarios
      issue(OP_ADD, 16'h7FFF, 16'h0001, 0, 1, 0);
      chk("t1_out", 32'(bus.out), 32'h8000);
      chk("t1_flags", 32'(bus.flags), 32'b00110);
      issue(OP_SUB, 16'h0003, 16'h0005, 0, 1, 0);
      issue(OP_JB, 16'h0, 16'h0, 0, 1, 0);
      chk("t2_jb", 32'({bus.out, bus.cond_true}), 32'({16'hFFFF, 1'b1}));
      issue(OP_SETC, 16'h0, 16'h0, 0, 1, 0);
      chk("t3_setc_wb", 32'(bus.wb_en), 32'd0);
      issue(OP_ADC, 16'hFFFF, 16'h0000, 0, 1, 0);
      issue(OP_CLC, 16'h0, 16'h0, 0, 1, 0);
      issue(OP_ROL, 16'h8001, 16'h0, 4, 1, 1);
      chk("t4_rol", 32'(bus.out), 32'h0018);
      issue(OP_CMP, 16'h0005, 16'h0005, 0, 1, 0);
      issue(OP_JE, 16'h0, 16'h0, 0, 1, 0);
      issue(OP_JNE, 16'h0, 16'h0, 0, 1, 0);
      issue(OP_SHRA, 16'h8000, 16'h0, 15, 1, 1);
      issue(OP_RCR, 16'h0001, 16'h0, 1, 1, 0);
      issue(8'hF0, 16'h1111, 16'h2222, 0, 1, 0);

      // Reset in the middle of a shift
      issue(OP_ROL, 16'hA5A5, 16'h0, 6, 0, 0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      q.delete(); m_out = '0; m_flags = '0;
      sh_to = cyc + 1; rst_cyc = cyc + 1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t5_busy", 32'(bus.busy), 32'd0);
      chk("t5_out", 32'({bus.out, bus.flags, bus.out_valid}), 32'd0);
      repeat (2) begin @(posedge clk); #1; end

      // Randomized stream
      for (int i = 0; i < 400; i++) begin
         op = op_list[$urandom_range(0, op_list.size() - 1)];
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
         issue(op, rnd_val(), rnd_val(), n, 1, 1);
         repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) begin
            @(posedge clk); #1;
         end
      end
      repeat (3) begin @(posedge clk); #1; end
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
